wire_pattern_gen: RTL and testbench

Upstream stimulus stage for the single-wire pass-through block. It drives that block's input bit with a square-wave pattern of NUM_PHASES phases, each HALF_PERIOD clock cycles long. Its cycle-accurate sequence replaces hand-written delay scripts. It has a start/busy/done handshake and a phase_tick strobe, so a downstream checker can sample the pass-through outputs at known points.

---
 rtl/wire_pattern_gen.sv | 122 ++++++++++++
 tb/tb_wire_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wire_pattern_gen.sv
// Square-wave stimulus generator for the single-wire pass-through block.
// A run produces NUM_PHASES phases of HALF_PERIOD cycles each, alternating
// a_out starting from INIT_LEVEL, with a start/busy/done handshake and a
// phase_tick strobe marking the first cycle of every phase after the first.
module wire_pattern_gen #(
    parameter int unsigned HALF_PERIOD = 20,
    parameter int unsigned NUM_PHASES  = 4,
    parameter logic        INIT_LEVEL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a_out,
    output logic       busy,
    output logic       done,
    output logic       phase_tick,
    output logic [7:0] phase_idx
);

    localparam logic [15:0] TimerLast = 16'(HALF_PERIOD - 1);
    localparam logic [7:0]  PhaseLast = 8'(NUM_PHASES - 1);

    // Reject parameter values outside the supported range at elaboration.
    if (HALF_PERIOD < 1 || HALF_PERIOD > 65535 || NUM_PHASES < 1 || NUM_PHASES > 255)
    begin : g_param_check
        $error("wire_pattern_gen: HALF_PERIOD or NUM_PHASES out of range");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  phase_idx_q, phase_idx_d;
    logic        a_out_q, a_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick_q, tick_d;

    // Next-state logic; every output is computed here and registered below.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        phase_idx_d = phase_idx_q;
        a_out_d     = a_out_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        tick_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    state_d     = StRun;
                    busy_d      = 1'b1;
                    timer_d     = 16'd0;
                    phase_idx_d = 8'd0;
                    a_out_d     = INIT_LEVEL;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d     = StIdle;
                    timer_d     = 16'd0;
                    phase_idx_d = 8'd0;
                    a_out_d     = INIT_LEVEL;
                end else if (timer_q == TimerLast) begin
                    timer_d = 16'd0;
                    if (phase_idx_q != PhaseLast) begin
                        phase_idx_d = phase_idx_q + 8'd1;
                        a_out_d     = ~a_out_q;
                        tick_d      = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        // last phase complete: a_out keeps the final level
                        state_d     = StDone;
                        phase_idx_d = 8'd0;
                        done_d      = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                    busy_d  = 1'b1;
                end
            end
            StDone: begin
                // start is deliberately not sampled here
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= 16'd0;
            phase_idx_q <= 8'd0;
            a_out_q     <= INIT_LEVEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            phase_idx_q <= phase_idx_d;
            a_out_q     <= a_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tick_q      <= tick_d;
        end
    end

    assign a_out      = a_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign phase_tick = tick_q;
    assign phase_idx  = phase_idx_q;

endmodule

// File: tb/tb_wire_pattern_gen.sv
// Directed bench for wire_pattern_gen: default configuration run from a
// checkpoint table, plus short sequences for start-held, abort, mid-run reset,
// HALF_PERIOD=1 and NUM_PHASES=1 corner cases.
module tb_wire_pattern_gen;

    logic clk;
    logic rst_n;

    // default instance: HP=20, NP=4, INIT=0
    logic       start_a, abort_a, a_a, busy_a, done_a, tick_a;
    logic [7:0] idx_a;
    // HP=1, NP=5, INIT=1
    logic       start_b, abort_b, a_b, busy_b, done_b, tick_b;
    logic [7:0] idx_b;
    // HP=3, NP=1, INIT=0
    logic       start_c, abort_c, a_c, busy_c, done_c, tick_c;
    logic [7:0] idx_c;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    wire_pattern_gen u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .abort      (abort_a),
        .a_out      (a_a),
        .busy       (busy_a),
        .done       (done_a),
        .phase_tick (tick_a),
        .phase_idx  (idx_a)
    );

    wire_pattern_gen #(
        .HALF_PERIOD (1),
        .NUM_PHASES  (5),
        .INIT_LEVEL  (1'b1)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .abort      (abort_b),
        .a_out      (a_b),
        .busy       (busy_b),
        .done       (done_b),
        .phase_tick (tick_b),
        .phase_idx  (idx_b)
    );

    wire_pattern_gen #(
        .HALF_PERIOD (3),
        .NUM_PHASES  (1),
        .INIT_LEVEL  (1'b0)
    ) u_dut_c (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_c),
        .abort      (abort_c),
        .a_out      (a_c),
        .busy       (busy_c),
        .done       (done_c),
        .phase_tick (tick_c),
        .phase_idx  (idx_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         cyc;
        logic       start;
        logic       a;
        logic       busy;
        logic       done;
        logic       tick;
        logic [7:0] idx;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vec [NVEC];

    // Expected per-cycle outputs for the two small-parameter instances, cycles 0..8
    int ea_b [9] = '{1, 1, 0, 1, 0, 1, 1, 1, 1};
    int eb_b [9] = '{0, 1, 1, 1, 1, 1, 0, 0, 0};
    int ed_b [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    int et_b [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    int ei_b [9] = '{0, 0, 1, 2, 3, 4, 0, 0, 0};
    int eb_c [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    int ed_c [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Two reset edges, then release; cycle 0 is the sample after the last reset edge.
    task automatic do_reset();
        rst_n   = 1'b0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        start_c = 1'b0; abort_c = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        int k;
        int n_tick;
        int n_done;
        int n_busy;

        // cyc, start(for next edge), a_out, busy, done, tick, idx
        vec[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vec[1]  = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vec[2]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vec[3]  = '{11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vec[4]  = '{30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vec[5]  = '{31, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        vec[6]  = '{32, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vec[7]  = '{50, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vec[8]  = '{51, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
        vec[9]  = '{70, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vec[10] = '{71, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3};
        vec[11] = '{90, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        vec[12] = '{91, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        vec[13] = '{92, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vec[14] = '{93, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vec[15] = '{95, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

        // ---- default run from the checkpoint table ----
        do_reset();
        k = 0; n_tick = 0; n_done = 0; n_busy = 0;
        for (int c = 0; c <= 95; c++) begin
            if (c > 0) step();
            start_a = 1'b0;
            n_tick += int'(tick_a);
            n_done += int'(done_a);
            n_busy += int'(busy_a);
            if (k < NVEC && vec[k].cyc == cyc) begin
                chk($sformatf("run c%0d a_out", cyc), int'(a_a), int'(vec[k].a));
                chk($sformatf("run c%0d busy", cyc), int'(busy_a), int'(vec[k].busy));
                chk($sformatf("run c%0d done", cyc), int'(done_a), int'(vec[k].done));
                chk($sformatf("run c%0d phase_tick", cyc), int'(tick_a), int'(vec[k].tick));
                chk($sformatf("run c%0d phase_idx", cyc), int'(idx_a), int'(vec[k].idx));
                start_a = vec[k].start;
                k++;
            end
        end
        chk("run checkpoints visited", k, NVEC);
        chk("run tick count", n_tick, 3);
        chk("run done count", n_done, 1);
        chk("run busy cycles", n_busy, 80);

        // ---- start held high from cycle 10 ----
        do_reset();
        n_done = 0; n_busy = 0;
        for (int c = 0; c <= 95; c++) begin
            if (c > 0) step();
            start_a = (cyc >= 10);
            if (cyc <= 92) begin
                n_done += int'(done_a);
                n_busy += int'(busy_a);
            end
            if (cyc == 11) chk("held c11 busy", int'(busy_a), 1);
            if (cyc == 91) chk("held c91 done", int'(done_a), 1);
            if (cyc == 92) chk("held c92 busy", int'(busy_a), 0);
            if (cyc == 93) begin
                chk("held c93 busy", int'(busy_a), 1);
                chk("held c93 a_out", int'(a_a), 0);
                chk("held c93 phase_idx", int'(idx_a), 0);
            end
        end
        chk("held done count", n_done, 1);
        chk("held busy cycles", n_busy, 80);

        // ---- abort mid-run, then start+abort together in IDLE ----
        do_reset();
        n_done = 0; n_tick = 0;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) step();
            start_a = (cyc == 10 || cyc == 50);
            abort_a = (cyc == 45 || cyc == 50);
            n_done += int'(done_a);
            if (cyc >= 46) n_tick += int'(tick_a);
            if (cyc == 45) begin
                chk("abort c45 busy", int'(busy_a), 1);
                chk("abort c45 a_out", int'(a_a), 1);
                chk("abort c45 phase_idx", int'(idx_a), 1);
            end
            if (cyc == 46) begin
                chk("abort c46 busy", int'(busy_a), 0);
                chk("abort c46 a_out", int'(a_a), 0);
                chk("abort c46 phase_idx", int'(idx_a), 0);
            end
            if (cyc == 51) chk("start+abort c51 busy", int'(busy_a), 0);
            if (cyc == 53) chk("start+abort c53 busy", int'(busy_a), 0);
        end
        chk("abort done count", n_done, 0);
        chk("abort tick count", n_tick, 0);

        // ---- synchronous reset mid-run ----
        do_reset();
        n_done = 0; n_tick = 0; n_busy = 0;
        for (int c = 0; c <= 120; c++) begin
            if (c > 0) step();
            start_a = (cyc == 10);
            rst_n   = (cyc != 60);
            if (cyc == 60) chk("rst c60 phase_idx", int'(idx_a), 2);
            if (cyc == 61) begin
                chk("rst c61 busy", int'(busy_a), 0);
                chk("rst c61 a_out", int'(a_a), 0);
                chk("rst c61 phase_idx", int'(idx_a), 0);
                chk("rst c61 done", int'(done_a), 0);
                chk("rst c61 phase_tick", int'(tick_a), 0);
            end
            if (cyc >= 61) begin
                n_done += int'(done_a);
                n_tick += int'(tick_a);
                n_busy += int'(busy_a);
            end
        end
        chk("rst done after", n_done, 0);
        chk("rst tick after", n_tick, 0);
        chk("rst busy after", n_busy, 0);

        // ---- HP=1/NP=5/INIT=1 and HP=3/NP=1 instances, start at cycle 0 ----
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) step();
            start_b = (cyc == 0);
            start_c = (cyc == 0);
            chk($sformatf("hp1 c%0d a_out", cyc), int'(a_b), ea_b[c]);
            chk($sformatf("hp1 c%0d busy", cyc), int'(busy_b), eb_b[c]);
            chk($sformatf("hp1 c%0d done", cyc), int'(done_b), ed_b[c]);
            chk($sformatf("hp1 c%0d phase_tick", cyc), int'(tick_b), et_b[c]);
            chk($sformatf("hp1 c%0d phase_idx", cyc), int'(idx_b), ei_b[c]);
            chk($sformatf("np1 c%0d a_out", cyc), int'(a_c), 0);
            chk($sformatf("np1 c%0d busy", cyc), int'(busy_c), eb_c[c]);
            chk($sformatf("np1 c%0d done", cyc), int'(done_c), ed_c[c]);
            chk($sformatf("np1 c%0d phase_tick", cyc), int'(tick_c), 0);
            chk($sformatf("np1 c%0d phase_idx", cyc), int'(idx_c), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
